// File: rtl/data_mem_if.sv
// data_mem_if: load/store memory bus between the memory controller (master) and data_mem (slave)
interface data_mem_if;
  logic [31:0] address;
  logic        read_enable;
  logic        write_enable;
  logic [3:0]  write_byte_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_ack;
  logic        write_ack;
  logic        access_fault;
  logic        protocol_err;
  modport master (
    output address, read_enable, write_enable, write_byte_enable, write_data,
    input  read_data, read_ack, write_ack, access_fault, protocol_err
  );
  modport slave (
    input  address, read_enable, write_enable, write_byte_enable, write_data,
    output read_data, read_ack, write_ack, access_fault, protocol_err
  );
endinterface

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory slave with fixed wait states and a two-cycle ack; DATA_MEM_RAND_WAIT_EN adds 0..3 random extra wait states in simulation
module data_mem #(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ACK1, ACK2} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d, lat;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d, oob_q, oob_d;
  logic        rack_q, rack_d, wack_q, wack_d, fault_q, fault_d, perr_q, perr_d;
  logic        accept, commit;
  logic [31:0] mem [DEPTH_WORDS];
`ifdef DATA_MEM_RAND_WAIT_EN
`ifndef SYNTHESIS
  logic [1:0] extra_q;
  // fresh random extra latency every cycle; sampled when an access is accepted
  always_ff @(posedge clk) extra_q <= 2'($urandom_range(0, 3));
  assign lat = 5'(WAIT_STATES) + 5'(extra_q);
`else
  assign lat = 5'(WAIT_STATES);
`endif
`else
  assign lat = 5'(WAIT_STATES);
`endif
  // next-state, capture and registered-output logic
  always_comb begin
    accept  = state_q == IDLE && (bus.read_enable || bus.write_enable);
    addr_d  = accept ? bus.address : addr_q;
    wdata_d = accept ? bus.write_data : wdata_q;
    be_d    = accept ? bus.write_byte_enable : be_q;
    wr_d    = accept ? bus.write_enable : wr_q;
    oob_d   = addr_d >= 32'(DEPTH_WORDS);
    cnt_d   = accept ? lat - 5'd1 : cnt_q - 5'(state_q == WAIT);
    state_d = accept ? (lat == 5'd0 ? ACK1 : WAIT)
            : state_q == WAIT ? (cnt_q == 5'd0 ? ACK1 : WAIT)
            : state_q == ACK1 ? ACK2 : IDLE;
    commit  = state_d == ACK1;
    rdata_d = commit && !wr_d ? (oob_d ? 32'h0 : mem[addr_d[AW-1:0]]) : rdata_q;
    rack_d  = (state_q == ACK1 || state_q == ACK2) && !wr_q;
    wack_d  = (state_q == ACK1 || state_q == ACK2) && wr_q;
    fault_d = state_q == ACK1 && oob_q;
    perr_d  = state_q != IDLE ? (bus.read_enable || bus.write_enable)
                              : (bus.read_enable && bus.write_enable);
  end
  // store commit on the edge entering ACK1; contents survive reset
  always_ff @(posedge clk)
    if (!rst && commit && wr_d && !oob_d)
      for (int i = 0; i < 4; i++)
        if (be_d[i]) mem[addr_d[AW-1:0]][8*i +: 8] <= wdata_d[8*i +: 8];
  // state and output registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      fault_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      oob_q   <= oob_d;
      rdata_q <= rdata_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
      fault_q <= fault_d;
      perr_q  <= perr_d;
    end
  assign bus.read_data    = rdata_q;
  assign bus.read_ack     = rack_q;
  assign bus.write_ack    = wack_q;
  assign bus.access_fault = fault_q;
  assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized and directed checks of data_mem against a word-array reference model
module tb_data_mem;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic re = 1'b0, we = 1'b0;
  logic [31:0] a = '0, wd = '0;
  logic [3:0] be = '0;
  int sel = 0;
  data_mem_if b0(), b1(), b2();
  data_mem #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  data_mem #(.DEPTH_WORDS(16), .WAIT_STATES(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  data_mem #(.DEPTH_WORDS(16), .WAIT_STATES(3)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  assign b0.read_enable = re && sel == 0;
  assign b1.read_enable = re && sel == 1;
  assign b2.read_enable = re && sel == 2;
  assign b0.write_enable = we && sel == 0;
  assign b1.write_enable = we && sel == 1;
  assign b2.write_enable = we && sel == 2;
  assign b0.address = a;
  assign b1.address = a;
  assign b2.address = a;
  assign b0.write_byte_enable = be;
  assign b1.write_byte_enable = be;
  assign b2.write_byte_enable = be;
  assign b0.write_data = wd;
  assign b1.write_data = wd;
  assign b2.write_data = wd;
  logic ra, wa, af, pe;
  logic [31:0] rd;
  assign ra = sel == 0 ? b0.read_ack : sel == 1 ? b1.read_ack : b2.read_ack;
  assign wa = sel == 0 ? b0.write_ack : sel == 1 ? b1.write_ack : b2.write_ack;
  assign af = sel == 0 ? b0.access_fault : sel == 1 ? b1.access_fault : b2.access_fault;
  assign pe = sel == 0 ? b0.protocol_err : sel == 1 ? b1.protocol_err : b2.protocol_err;
  assign rd = sel == 0 ? b0.read_data : sel == 1 ? b1.read_data : b2.read_data;
  int ws_of [3] = '{0, 1, 3};
  logic [31:0] mm [3][16];
  logic [31:0] rdm [3];
  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one access on DUT k, called at a negedge; intr>0 pulses a stray read strobe at that cycle
  task automatic acc(input int k, input bit r, input bit w, input logic [31:0] ad,
                     input logic [3:0] bb, input logic [31:0] d, input int intr);
    int ws = ws_of[k];
    bit oob = ad >= 32'd16;
    logic [7:0] rav = '0, wav = '0, afv = '0, pev = '0;
    logic [7:0] era = '0, ewa = '0, eaf = '0, epe = '0;
    logic [31:0] rdv = '0;
    sel = k; re = r; we = w; a = ad; be = bb; wd = d;
    for (int j = 1; j <= ws + 3; j++) begin
      @(negedge clk);
      re = (j == intr); we = 1'b0;
      rav[j] = ra; wav[j] = wa; afv[j] = af; pev[j] = pe;
      if (j == ws + 3) rdv = rd;
    end
    re = 1'b0;
    epe[1] = r && w;
    if (intr >= 1 && intr <= ws + 2) epe[intr+1] = 1'b1;
    if (w) begin ewa[ws+2] = 1'b1; ewa[ws+3] = 1'b1; end
    else begin era[ws+2] = 1'b1; era[ws+3] = 1'b1; end
    eaf[ws+2] = oob;
    if (w && !oob)
      for (int i = 0; i < 4; i++) if (bb[i]) mm[k][ad[3:0]][8*i +: 8] = d[8*i +: 8];
    if (r && !w) rdm[k] = oob ? 32'h0 : mm[k][ad[3:0]];
    chk("read_ack", 32'(rav), 32'(era));
    chk("write_ack", 32'(wav), 32'(ewa));
    chk("access_fault", 32'(afv), 32'(eaf));
    chk("protocol_err", 32'(pev), 32'(epe));
    chk("read_data", rdv, rdm[k]);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #0 chk("reset outs", {28'h0, ra, wa, af, pe}, 32'h0);
      chk("reset read_data", rd, 32'h0);
      rdm[k] = 32'h0;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) acc(k, 0, 1, 32'(i), 4'hF, $urandom, 0);
    acc(1, 0, 1, 32'd5, 4'hF, 32'hDEADBEEF, 0);
    acc(1, 1, 0, 32'd5, 4'h0, 32'h0, 0);
    chk("deadbeef", rdm[1], 32'hDEADBEEF);
    acc(1, 0, 1, 32'd7, 4'hF, 32'h11223344, 0);
    acc(1, 0, 1, 32'd7, 4'h2, 32'h0000AA00, 0);
    acc(1, 1, 0, 32'd7, 4'h0, 32'h0, 0);
    chk("byte lane", rdm[1], 32'h1122AA44);
    acc(1, 0, 1, 32'd7, 4'h0, 32'hFFFFFFFF, 0);
    acc(1, 1, 0, 32'd7, 4'h0, 32'h0, 0);
    chk("be zero", rdm[1], 32'h1122AA44);
    acc(1, 1, 0, 32'd16, 4'h0, 32'h0, 0);
    acc(1, 0, 1, 32'd20, 4'hF, 32'hCAFEF00D, 0);
    acc(1, 1, 0, 32'd4, 4'h0, 32'h0, 0);
    acc(1, 1, 0, 32'd5, 4'h0, 32'h0, 1);
    acc(1, 1, 1, 32'd3, 4'hF, 32'h5A5A0F0F, 0);
    acc(1, 1, 0, 32'd3, 4'h0, 32'h0, 0);
    acc(0, 1, 0, 32'd0, 4'h0, 32'h0, 0);
    acc(0, 1, 0, 32'd1, 4'h0, 32'h0, 0);
    sel = 2; we = 1'b1; a = 32'd9; be = 4'hF; wd = ~mm[2][9];
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) rdm[k] = 32'h0;
    for (int j = 0; j < 5; j++) begin
      chk("rst abort outs", {28'h0, ra, wa, af, pe}, 32'h0);
      chk("rst abort read_data", rd, 32'h0);
      @(negedge clk);
    end
    acc(2, 1, 0, 32'd9, 4'h0, 32'h0, 0);
    for (int n = 0; n < 60; n++) begin
      int k = $urandom_range(0, 2);
      int op = $urandom_range(0, 5);
      acc(k, op != 1 && op != 2, op == 1 || op == 2 || op == 5, 32'($urandom_range(0, 19)),
          4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0 ? 1 : 0);
    end
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) acc(k, 1, 0, 32'(i), 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("final idle", {28'h0, ra, wa, af, pe}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
